// File: rtl/cmp_entry_sequencer.sv
// Press-driven front end for the DE10-Lite 4-bit magnitude comparator.
// Operands A then B are captured on debounced KEY1 presses, compared once, and the result is shown for a timed window.
module cmp_entry_sequencer #(
   parameter int WIDTH        = 4,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int SHOW_CYC     = 100000000
) (
   input  logic       MAX10_CLK1_50,
   input  logic       KEY0,
   input  logic       KEY1,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [7:0] HEX0,
   output logic [7:0] HEX1,
   output logic [7:0] HEX2,
   output logic [7:0] HEX3,
   output logic [7:0] HEX4,
   output logic [7:0] HEX5
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int TM_W = $clog2(SHOW_CYC + 1);

   typedef enum logic [1:0] {
      WAIT_A = 2'b00,
      WAIT_B = 2'b01,
      CMP    = 2'b10,
      SHOW   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_E    = 2'd1,
      RES_L    = 2'd2,
      RES_G    = 2'd3
   } result_t;

   logic             keySync1_q, keySync2_q;
   logic             clrSync1_q, clrSync2_q;
   logic             keyStable_q, keyStable_d;
   logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
   logic             press_q, press_d;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic             aValid_q, aValid_d;
   logic             bValid_q, bValid_d;
   result_t          result_q, result_d;
   logic [3:0]       tallyE_q, tallyE_d;
   logic [3:0]       tallyL_q, tallyL_d;
   logic [3:0]       tallyG_q, tallyG_d;
   logic [TM_W-1:0]  timer_q, timer_d;

   logic [2:0]       resLed;
   logic             unusedSw;

   assign unusedSw = ^SW[8:WIDTH];

   // KEY1 idles high, so its synchronizer and accepted level reset high to avoid a phantom edge.
   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         keySync1_q  <= 1'b1;
         keySync2_q  <= 1'b1;
         clrSync1_q  <= 1'b0;
         clrSync2_q  <= 1'b0;
         keyStable_q <= 1'b1;
         dbCnt_q     <= '0;
         press_q     <= 1'b0;
         state_q     <= WAIT_A;
         opA_q       <= '0;
         opB_q       <= '0;
         aValid_q    <= 1'b0;
         bValid_q    <= 1'b0;
         result_q    <= RES_NONE;
         tallyE_q    <= '0;
         tallyL_q    <= '0;
         tallyG_q    <= '0;
         timer_q     <= '0;
      end else begin
         keySync1_q  <= KEY1;
         keySync2_q  <= keySync1_q;
         clrSync1_q  <= SW[9];
         clrSync2_q  <= clrSync1_q;
         keyStable_q <= keyStable_d;
         dbCnt_q     <= dbCnt_d;
         press_q     <= press_d;
         state_q     <= state_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         aValid_q    <= aValid_d;
         bValid_q    <= bValid_d;
         result_q    <= result_d;
         tallyE_q    <= tallyE_d;
         tallyL_q    <= tallyL_d;
         tallyG_q    <= tallyG_d;
         timer_q     <= timer_d;
      end
   end

   // The counter runs only while the synchronized key disagrees with the accepted level.
   always_comb begin
      keyStable_d = keyStable_q;
      dbCnt_d     = '0;
      press_d     = 1'b0;
      if (keySync2_q != keyStable_q) begin
         if (dbCnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            keyStable_d = keySync2_q;
            press_d     = ~keySync2_q;
         end else begin
            dbCnt_d = dbCnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      aValid_d = aValid_q;
      bValid_d = bValid_q;
      result_d = result_q;
      tallyE_d = tallyE_q;
      tallyL_d = tallyL_q;
      tallyG_d = tallyG_q;
      timer_d  = timer_q;
      case (state_q)
         WAIT_A: begin
            if (press_q) begin
               opA_d    = SW[WIDTH-1:0];
               aValid_d = 1'b1;
               bValid_d = 1'b0;
               state_d  = WAIT_B;
            end
         end
         WAIT_B: begin
            if (press_q) begin
               opB_d    = SW[WIDTH-1:0];
               bValid_d = 1'b1;
               state_d  = CMP;
            end
         end
         CMP: begin
            if (opA_q == opB_q) begin
               result_d = RES_E;
               tallyE_d = (tallyE_q == 4'hF) ? tallyE_q : tallyE_q + 4'd1;
            end else if (opA_q < opB_q) begin
               result_d = RES_L;
               tallyL_d = (tallyL_q == 4'hF) ? tallyL_q : tallyL_q + 4'd1;
            end else begin
               result_d = RES_G;
               tallyG_d = (tallyG_q == 4'hF) ? tallyG_q : tallyG_q + 4'd1;
            end
            timer_d = TM_W'(SHOW_CYC - 1);
            state_d = SHOW;
         end
         SHOW: begin
            if (press_q) begin
               opA_d    = SW[WIDTH-1:0];
               aValid_d = 1'b1;
               bValid_d = 1'b0;
               state_d  = WAIT_B;
            end else if (timer_q == '0) begin
               state_d = WAIT_A;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = WAIT_A;
      endcase
      if (clrSync2_q) begin
         tallyE_d = '0;
         tallyL_d = '0;
         tallyG_d = '0;
      end
   end

   function automatic logic [7:0] hexSeg(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Outputs are pure decodes of registered state, so no input reaches them combinationally.
   always_comb begin
      resLed = 3'b000;
      HEX3   = 8'hFF;
      case (result_q)
         RES_E: begin
            resLed = 3'b100;
            HEX3   = 8'h86;
         end
         RES_L: begin
            resLed = 3'b001;
            HEX3   = 8'hC7;
         end
         RES_G: resLed = 3'b010;
         default: resLed = 3'b000;
      endcase
   end

   assign LEDR = {5'b00000, state_q, resLed};
   assign HEX0 = hexSeg(tallyE_q);
   assign HEX1 = hexSeg(tallyL_q);
   assign HEX2 = hexSeg(tallyG_q);
   assign HEX4 = bValid_q ? hexSeg(4'(opB_q)) : 8'hFF;
   assign HEX5 = aValid_q ? hexSeg(4'(opA_q)) : 8'hFF;

endmodule

// File: tb/tb_cmp_entry_sequencer.sv
// Self-checking bench for cmp_entry_sequencer: directed and random operand entry against a press-level behavioural model.
module tb_cmp_entry_sequencer;

   localparam int DB    = 4;
   localparam int SHOWC = 16;
   localparam logic [7:0] SEG_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic       clock = 1'b0;
   logic       KEY0, KEY1;
   logic [9:0] SW;
   logic [9:0] LEDR;
   logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int checks = 0;
   int errors = 0;

   int mState, mOpA, mOpB, mRes;
   bit mAValid, mBValid;
   int mTally [3];

   always #5 clock = ~clock;

   cmp_entry_sequencer #(
      .WIDTH(4),
      .DEBOUNCE_CYC(DB),
      .SHOW_CYC(SHOWC)
   ) dut (
      .MAX10_CLK1_50(clock),
      .KEY0(KEY0),
      .KEY1(KEY1),
      .SW(SW),
      .LEDR(LEDR),
      .HEX0(HEX0),
      .HEX1(HEX1),
      .HEX2(HEX2),
      .HEX3(HEX3),
      .HEX4(HEX4),
      .HEX5(HEX5)
   );

   task automatic modelReset();
      mState  = 0;
      mOpA    = 0;
      mOpB    = 0;
      mRes    = 0;
      mAValid = 0;
      mBValid = 0;
      for (int i = 0; i < 3; i++) mTally[i] = 0;
   endtask

   task automatic modelCaptureA(input int v);
      mOpA    = v;
      mAValid = 1;
      mBValid = 0;
      mState  = 1;
   endtask

   // Result index: 0 equal, 1 less, 2 greater; display code is index+1.
   task automatic modelCaptureB(input int v, input bit clr);
      int idx;
      mOpB    = v;
      mBValid = 1;
      idx     = (mOpA == mOpB) ? 0 : ((mOpA < mOpB) ? 1 : 2);
      mRes    = idx + 1;
      if (clr) begin
         for (int i = 0; i < 3; i++) mTally[i] = 0;
      end else if (mTally[idx] < 15) begin
         mTally[idx]++;
      end
      mState = 3;
   endtask

   task automatic checkVal(input string tag, input string what, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s/%s actual=%h required=%h", tag, what, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [2:0] oneHot;
      logic [7:0] eHex3;
      oneHot = (mRes == 1) ? 3'b100 : (mRes == 2) ? 3'b001 : (mRes == 3) ? 3'b010 : 3'b000;
      eHex3  = (mRes == 1) ? 8'h86 : (mRes == 2) ? 8'hC7 : 8'hFF;
      checkVal(tag, "LEDR", LEDR, {5'b0, 2'(mState), oneHot});
      checkVal(tag, "HEX0", {2'b0, HEX0}, {2'b0, SEG_TAB[mTally[0]]});
      checkVal(tag, "HEX1", {2'b0, HEX1}, {2'b0, SEG_TAB[mTally[1]]});
      checkVal(tag, "HEX2", {2'b0, HEX2}, {2'b0, SEG_TAB[mTally[2]]});
      checkVal(tag, "HEX3", {2'b0, HEX3}, {2'b0, eHex3});
      checkVal(tag, "HEX4", {2'b0, HEX4}, {2'b0, mBValid ? SEG_TAB[mOpB] : 8'hFF});
      checkVal(tag, "HEX5", {2'b0, HEX5}, {2'b0, mAValid ? SEG_TAB[mOpA] : 8'hFF});
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Holds KEY1 low for `hold` cycles then high for `rel` cycles, with the operand on SW[3:0].
   task automatic applyStimulus(input logic [3:0] val, input int hold, input int rel);
      SW[3:0] = val;
      KEY1    = 1'b0;
      waitCycles(hold);
      KEY1 = 1'b1;
      waitCycles(rel);
   endtask

   task automatic doCompare(input string tag, input int a, input int b, input bit clr);
      applyStimulus(4'(a), 10, 8);
      modelCaptureA(a);
      checkOutput({tag, "_A"});
      applyStimulus(4'(b), 10, 8);
      modelCaptureB(b, clr);
      checkOutput({tag, "_B"});
      waitCycles(8);
      mState = 0;
      checkOutput({tag, "_idle"});
   endtask

   initial begin
      int lat;
      bit found;
      int a, b;

      KEY0 = 1'b0;
      KEY1 = 1'b1;
      SW   = '0;
      modelReset();
      waitCycles(3);
      checkOutput("resetHeld");
      KEY0 = 1'b1;
      waitCycles(2);
      checkOutput("resetRel");

      // First capture: measure press-to-display latency with a bounded wait.
      SW[3:0] = 4'd5;
      KEY1    = 1'b0;
      lat     = 0;
      found   = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         lat++;
         if (HEX5 !== 8'hFF) found = 1;
      end
      checks++;
      assert (found && lat == DB + 3) else begin
         errors++;
         $error("[TB] FAIL pressLatency actual=%0d required=%0d", lat, DB + 3);
      end
      if (lat < 10) waitCycles(10 - lat);
      KEY1 = 1'b1;
      waitCycles(8);
      modelCaptureA(5);
      checkOutput("capA5");
      applyStimulus(4'd5, 10, 8);
      modelCaptureB(5, 0);
      checkOutput("cmp55");
      waitCycles(5);
      checkOutput("showLast");
      waitCycles(1);
      mState = 0;
      checkOutput("showExpire");

      doCompare("lt39", 3, 9, 0);
      doCompare("gtF0", 15, 0, 0);

      SW[3:0] = 4'hA;
      for (int g = 0; g < 8; g++) begin
         KEY1 = 1'b0;
         waitCycles($urandom_range(1, 3));
         KEY1 = 1'b1;
         waitCycles($urandom_range(1, 3));
      end
      waitCycles(8);
      checkOutput("glitch");
      applyStimulus(4'hA, 10, 8);
      modelCaptureA(10);
      checkOutput("onePress");
      b = $urandom_range(0, 15);
      applyStimulus(4'(b), 10, 8);
      modelCaptureB(b, 0);
      checkOutput("onePressB");
      waitCycles(8);
      mState = 0;
      checkOutput("onePressIdle");

      for (int i = 0; i < 8; i++) begin
         a = $urandom_range(0, 15);
         b = (i % 3 == 0) ? a : $urandom_range(0, 15);
         doCompare("rand", a, b, 0);
      end

      for (int i = 0; i < 16; i++) begin
         a = $urandom_range(0, 15);
         doCompare("sat", a, a, 0);
      end
      checkVal("satE", "HEX0", {2'b0, HEX0}, {2'b0, 8'h8E});

      applyStimulus(4'd2, 10, 8);
      modelCaptureA(2);
      SW[9] = 1'b1;
      applyStimulus(4'd2, 10, 8);
      modelCaptureB(2, 1);
      checkOutput("clrCmp");
      SW[9] = 1'b0;
      waitCycles(8);
      mState = 0;
      checkOutput("clrAfter");

      // Short B press and release so the next press lands while SHOW is still counting.
      applyStimulus(4'd1, 10, 8);
      modelCaptureA(1);
      applyStimulus(4'd3, 7, 6);
      modelCaptureB(3, 0);
      checkOutput("showB");
      applyStimulus(4'd7, 10, 8);
      modelCaptureA(7);
      checkOutput("showPress");

      KEY0 = 1'b0;
      waitCycles(1);
      KEY0 = 1'b1;
      waitCycles(2);
      modelReset();
      checkOutput("midReset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
